pipe_mem_access: RTL

MEM-stage data-memory access unit. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. Issues loads and stores to a variable-latency data bus through a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and hands sign/zero-extended load data plus the writeback controls to MEM/WB.

---
 rtl/pipe_mem_access_pkg.sv | 76 +++++++
 rtl/pipe_mem_access_ext.sv | 31 +++
 rtl/pipe_mem_access.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Holds the mem-op encodings, FSM state encoding, byte-enable and
// load-extension constants, plus small decode helpers used by the top
// and by the load-extension sub-module.
package pipe_mem_access_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    EXT_SB = 3'd0,  // sign-extend byte
    EXT_ZB = 3'd1,  // zero-extend byte
    EXT_SH = 3'd2,  // sign-extend half
    EXT_ZH = 3'd3,  // zero-extend half
    EXT_W  = 3'd4   // full word
  } ext_mode_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

  function automatic ext_mode_e ext_mode(input logic [3:0] op);
    case (op)
      OP_LB:   return EXT_SB;
      OP_LBU:  return EXT_ZB;
      OP_LH:   return EXT_SH;
      OP_LHU:  return EXT_ZH;
      default: return EXT_W;
    endcase
  endfunction

  // Enables are placed in the addressed lane; halves only ever sit at lane 0 or 2.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return BE_BYTE << a;
      SZ_H:    return BE_HALF << {a[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mem_access_ext.sv
// mem_load_ext: combinational little-endian lane select and sign/zero
// extension of a bus read word.
//   rdata  [31:0] raw word from the bus
//   addr   [1:0]  byte offset within the word
//   mem_op [3:0]  access type (selects width and signedness)
//   result [31:0] extended load value
module mem_load_ext
  import pipe_mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  mem_op,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ext_mode(mem_op))
      EXT_SB:  result = {{24{b[7]}}, b};
      EXT_ZB:  result = {24'd0, b};
      EXT_SH:  result = {{16{h[15]}}, h};
      EXT_ZH:  result = {16'd0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/pipe_mem_access.sv
// pipe_mem_access: MEM-stage data-memory access unit.
// Issues one load/store at a time on a req/ack data bus, stalls the
// upstream pipeline while the access is outstanding, and hands extended
// load data plus writeback controls to MEM/WB.
// Ports:
//   in_clk, in_rst                 clock, async active-high reset
//   in_mem_op/alu_result/store_data/rd_*   EX/MEM fields
//   out_bus_req/we/addr/be/wdata   registered bus request
//   in_bus_ack, in_bus_rdata       bus completion strobe and read word
//   out_stall, out_misalign        combinational hazard / fault flags
//   out_rd_*, out_alu_result       MEM/WB controls
//   out_dmem_data                  registered extended load data
module pipe_mem_access
  import pipe_mem_access_pkg::*;
(
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd_waddr,
  input  logic        in_rd_sel,
  input  logic        in_rd_wena,
  output logic        out_bus_req,
  output logic        out_bus_we,
  output logic [31:0] out_bus_addr,
  output logic [3:0]  out_bus_be,
  output logic [31:0] out_bus_wdata,
  input  logic        in_bus_ack,
  input  logic [31:0] in_bus_rdata,
  output logic        out_stall,
  output logic        out_misalign,
  output logic [4:0]  out_rd_waddr,
  output logic        out_rd_sel,
  output logic [31:0] out_alu_result,
  output logic        out_rd_wena,
  output logic [31:0] out_dmem_data
);

  state_e      state;
  logic        is_load, is_store, is_mem;
  logic [1:0]  sz, a;
  logic [31:0] ext_data, wdata_rep;

  assign a        = in_alu_result[1:0];
  assign is_load  = op_is_load(in_mem_op);
  assign is_store = op_is_store(in_mem_op);
  assign is_mem   = is_load | is_store;
  assign sz       = op_size(in_mem_op);

  assign out_misalign = is_mem && (((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'd0)));

  // EX/MEM is frozen while BUSY, so the live inputs still describe the access.
  assign out_stall = ((state == ST_IDLE) && is_mem && !out_misalign) || (state == ST_BUSY);

  assign out_rd_waddr   = in_rd_waddr;
  assign out_rd_sel     = in_rd_sel;
  assign out_alu_result = in_alu_result;
  assign out_rd_wena    = in_rd_wena & ~out_stall & ~out_misalign;

  always_comb begin
    case (sz)
      SZ_B:    wdata_rep = {4{in_store_data[7:0]}};
      SZ_H:    wdata_rep = {2{in_store_data[15:0]}};
      default: wdata_rep = in_store_data;
    endcase
  end

  mem_load_ext u_ext (
    .rdata  (in_bus_rdata),
    .addr   (a),
    .mem_op (in_mem_op),
    .result (ext_data)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state         <= ST_IDLE;
      out_bus_req   <= 1'b0;
      out_bus_we    <= 1'b0;
      out_bus_addr  <= 32'd0;
      out_bus_be    <= 4'd0;
      out_bus_wdata <= 32'd0;
      out_dmem_data <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !out_misalign) begin
            out_bus_req   <= 1'b1;
            out_bus_we    <= is_store;
            out_bus_addr  <= {in_alu_result[31:2], 2'b00};
            out_bus_be    <= byte_en(sz, a);
            out_bus_wdata <= wdata_rep;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_bus_ack) begin
            out_bus_req <= 1'b0;
            if (is_load) out_dmem_data <= ext_data;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
